txdata_pkt_fifo: RTL and testbench
==================================

# txdata_pkt_fifo

Single-clock, parametrised, packet-aware TX data FIFO for the LMAC AXIS bridge transmit path, between the AXIS slave front-end and the MAC TX engine. It carries a per-word end-of-packet marker and counts complete packets. It supports store-and-forward operation with packet abort and overflow drop, so the MAC never starts a frame that cannot be completed. The block replaces the vendor-IP dual-clock data FIFO wherever the bridge and MAC share a clock.

## Interface
- WIDTH, 64, data word width in bits
- DEPTH, 256, number of words; must equal 2**PTR
- PTR, 8, address width
- AFULL_TH, 240, wrafull asserts when wrusedw >= AFULL_TH
- clk  in  1  single clock for write and read sides
- reset_  in  1  reset; synchronous, active-low
- wren  in  1  write request
- datain  in  WIDTH  write data
- wrlast  in  1  datain is the last word of a packet
- wrabort  in  1  discard the packet currently being written (store-and-forward only)
- wrfull  out  1  wrusedw == DEPTH
- wrafull  out  1  almost full
- wrusedw  out  PTR+1  words held, including uncommitted words
- rden  in  1  read request
- dataout  out  WIDTH  read data, registered
- dataout_last  out  1  last-word flag of dataout
- rdempty  out  1  no readable word
- rdusedw  out  PTR+1  readable words
- pktcnt  out  PTR+1  complete packets held
- ovf  out  1  sticky overflow flag; cleared only by reset
- udf  out  1  sticky underflow flag; cleared only by reset
- dbg  out  1  high while the write FSM is in DROP; tied 0 when the FSM is compiled out

## Operation
- Storage: DEPTH x (WIDTH+1) RAM; the wrlast bit is stored with each word.
- Pointers are PTR+1 bits and wrap modulo 2**(PTR+1): wr_ptr, commit_ptr, rd_ptr.
- Occupancy: wrusedw = wr_ptr - rd_ptr. rdusedw = commit_ptr - rd_ptr. rdempty = (rdusedw == 0).
- Write FSM states:
  - IDLE: first accepted word moves to INPKT; a word with wrlast commits and stays in IDLE.
  - INPKT: accepted word with wrlast sets commit_ptr = wr_ptr+1 and returns to IDLE.
  - INPKT, wrabort: wr_ptr = commit_ptr, go to IDLE. Data on the abort cycle is discarded.
  - INPKT or IDLE, wren while wrfull: set ovf, rewind wr_ptr = commit_ptr, go to DROP.
  - DROP: all words are discarded until a word with wrlast arrives, then go to IDLE.
- A packet larger than DEPTH always ends in DROP, so there is no deadlock.
- pktcnt: +1 on commit; -1 when a word with stored last=1 is read. A commit and a last-word read in the same cycle leave pktcnt unchanged.
- Read: rden with !rdempty loads RAM[rd_ptr] into dataout/dataout_last and increments rd_ptr. rden while rdempty sets udf and changes nothing else.
- wrfull is evaluated on the current state. A write at full is rejected even when rden occurs in the same cycle.
- wrabort is ignored in IDLE and DROP.

## Timing
- Read latency: dataout is valid 1 cycle after the accepted rden. It holds its value otherwise.
- A committed word is visible on rdempty/rdusedw in the cycle after the commit write. Write-to-read minimum latency: 2 cycles.
- All status outputs are registered and update in the cycle after the causing event.
- Reset (reset_=0 at a clk edge) clears all pointers, returns the FSM to IDLE, and clears ovf/udf.
- Reset values: dataout 0, dataout_last 0, wrfull 0, wrafull 0, wrusedw 0, rdempty 1, rdusedw 0, pktcnt 0, ovf 0, udf 0, dbg 0.
- Reset mid-packet discards everything held, including uncommitted words.

## Configuration
- TXDATA_PKT_FIFO_STORE_FWD_EN defined: store-and-forward behaviour as described above.
- TXDATA_PKT_FIFO_STORE_FWD_EN undefined: cut-through behaviour.
  - commit_ptr tracks wr_ptr every cycle, so rdusedw == wrusedw.
  - wrabort is ignored and the FSM is removed.
  - A write at full is discarded and sets ovf, with no rewind and no drop of the remaining packet words.
  - pktcnt still counts words written with wrlast.

## Structure
- Package txdata_pkt_fifo_pkg holds:
  - the write FSM state typedef (IDLE, INPKT, DROP)
  - the default WIDTH/DEPTH/PTR/AFULL_TH constants
- Sub-module txdata_pkt_fifo_ram: simple dual-port RAM with a registered read port, WIDTH+1 bits wide.
- Pointer, FSM, and flag logic stay in the top level.

## Test plan
- Write 4-word packet A1..A4 (last on A4), then rden x4: rdempty stays 1 until the cycle after A4. Reads return A1..A4 at 1-cycle latency with dataout_last=1 on A4. pktcnt goes 0->1->0.
- Write 3 words, assert wrabort on the 4th: wrusedw returns to 0, rdempty stays 1, pktcnt 0, a following packet reads out intact.
- Write a 300-word packet (DEPTH 256): ovf=1 at word 257, dbg=1 until wrlast, wrusedw=0 afterwards, FIFO usable for the next packet.
- Fill to 256 committed words with rden and wren in the same cycle: write rejected, ovf=1, one word read, wrusedw=255.
- rden at reset exit: udf=1, dataout=0. Apply reset_=0 mid-packet: all outputs return to reset values.
- Cut-through build (macro undefined): a single word without wrlast is readable 2 cycles after write, and wrabort has no effect.

Source files
------------

// File: rtl/txdata_pkt_fifo_pkg.sv
// Shared constants and write-FSM state type for the packet-aware TX data FIFO.
package txdata_pkt_fifo_pkg;
  localparam int WIDTH_D    = 64;
  localparam int DEPTH_D    = 256;
  localparam int PTR_D      = 8;
  localparam int AFULL_TH_D = 240;

  typedef enum logic [1:0] {IDLE, INPKT, DROP} wr_state_e;
endpackage

// File: rtl/txdata_pkt_fifo_ram.sv
// Simple dual-port RAM, one write port and one registered read port (reset clears the read register).
module txdata_pkt_fifo_ram
  import txdata_pkt_fifo_pkg::*;
#(
  parameter int W     = WIDTH_D + 1,
  parameter int DEPTH = DEPTH_D,
  parameter int PTR   = PTR_D
) (
  input  logic           clk,
  input  logic           reset_,
  input  logic           we,
  input  logic [PTR-1:0] waddr,
  input  logic [W-1:0]   wdata,
  input  logic           re,
  input  logic [PTR-1:0] raddr,
  output logic [W-1:0]   rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  always_ff @(posedge clk)
    if (!reset_)  rdata <= '0;
    else if (re)  rdata <= mem[raddr];
endmodule

// File: rtl/txdata_pkt_fifo.sv
// Packet-aware single-clock TX data FIFO. TXDATA_PKT_FIFO_STORE_FWD_EN selects
// store-and-forward (commit on last, abort, overflow drop); undefined gives cut-through.
module txdata_pkt_fifo
  import txdata_pkt_fifo_pkg::*;
#(
  parameter int WIDTH    = WIDTH_D,
  parameter int DEPTH    = DEPTH_D,
  parameter int PTR      = PTR_D,
  parameter int AFULL_TH = AFULL_TH_D
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             wren,
  input  logic [WIDTH-1:0] datain,
  input  logic             wrlast,
  input  logic             wrabort,
  output logic             wrfull,
  output logic             wrafull,
  output logic [PTR:0]     wrusedw,
  input  logic             rden,
  output logic [WIDTH-1:0] dataout,
  output logic             dataout_last,
  output logic             rdempty,
  output logic [PTR:0]     rdusedw,
  output logic [PTR:0]     pktcnt,
  output logic             ovf,
  output logic             udf,
  output logic             dbg
);
  localparam logic [PTR:0] ONE = (PTR+1)'(1);

  logic [PTR:0]     wr_ptr, commit_ptr, rd_ptr;
  logic [PTR:0]     wr_ptr_n, commit_ptr_n, rd_ptr_n, wused_n;
  logic             ram_we, commit, ovf_set, rd_ok, rd_last;
  logic [DEPTH-1:0] last_mem;
  logic [WIDTH:0]   ram_q;

  assign rd_ok    = rden && !rdempty;
  assign rd_ptr_n = rd_ptr + (PTR+1)'(rd_ok);
  assign wused_n  = wr_ptr_n - rd_ptr_n;
  // Shadow copy of the stored last bits so pktcnt can drop on the read-request edge.
  assign rd_last  = last_mem[rd_ptr[PTR-1:0]];

`ifdef TXDATA_PKT_FIFO_STORE_FWD_EN
  wr_state_e state;

  always_comb begin
    wr_ptr_n     = wr_ptr;
    commit_ptr_n = commit_ptr;
    ram_we       = 1'b0;
    commit       = 1'b0;
    ovf_set      = 1'b0;
    if (state != DROP) begin
      if (state == INPKT && wrabort) begin
        wr_ptr_n = commit_ptr;
      end else if (wren && wrfull) begin
        ovf_set  = 1'b1;
        wr_ptr_n = commit_ptr;
      end else if (wren) begin
        ram_we   = 1'b1;
        wr_ptr_n = wr_ptr + ONE;
        if (wrlast) begin
          commit       = 1'b1;
          commit_ptr_n = wr_ptr + ONE;
        end
      end
    end
  end

  always_ff @(posedge clk)
    if (!reset_) begin
      state <= IDLE;
      dbg   <= 1'b0;
    end else begin
      case (state)
        IDLE, INPKT:
          if (state == INPKT && wrabort) begin
            state <= IDLE;
            dbg   <= 1'b0;
          end else if (wren && wrfull) begin
            state <= DROP;
            dbg   <= 1'b1;
          end else if (wren) begin
            state <= wrlast ? IDLE : INPKT;
            dbg   <= 1'b0;
          end
        default:
          if (wren && wrlast) begin
            state <= IDLE;
            dbg   <= 1'b0;
          end
      endcase
    end
`else
  logic unused_abort;
  assign unused_abort = wrabort;
  assign dbg          = 1'b0;

  always_comb begin
    wr_ptr_n = wr_ptr;
    ram_we   = 1'b0;
    commit   = 1'b0;
    ovf_set  = 1'b0;
    if (wren) begin
      if (wrfull) begin
        ovf_set = 1'b1;
      end else begin
        ram_we   = 1'b1;
        wr_ptr_n = wr_ptr + ONE;
        commit   = wrlast;
      end
    end
    commit_ptr_n = wr_ptr_n;
  end
`endif

  always_ff @(posedge clk)
    if (ram_we) last_mem[wr_ptr[PTR-1:0]] <= wrlast;

  always_ff @(posedge clk)
    if (!reset_) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      wrusedw    <= '0;
      rdusedw    <= '0;
      wrfull     <= 1'b0;
      wrafull    <= 1'b0;
      rdempty    <= 1'b1;
      pktcnt     <= '0;
      ovf        <= 1'b0;
      udf        <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_n;
      commit_ptr <= commit_ptr_n;
      rd_ptr     <= rd_ptr_n;
      wrusedw    <= wused_n;
      rdusedw    <= commit_ptr_n - rd_ptr_n;
      wrfull     <= wused_n == (PTR+1)'(DEPTH);
      wrafull    <= wused_n >= (PTR+1)'(AFULL_TH);
      rdempty    <= commit_ptr_n == rd_ptr_n;
      if (ovf_set)          ovf <= 1'b1;
      if (rden && rdempty)  udf <= 1'b1;
      case ({commit, rd_ok && rd_last})
        2'b10:   pktcnt <= pktcnt + ONE;
        2'b01:   pktcnt <= pktcnt - ONE;
        default: ;
      endcase
    end

  txdata_pkt_fifo_ram #(.W(WIDTH+1), .DEPTH(DEPTH), .PTR(PTR)) u_ram (
    .clk    (clk),
    .reset_ (reset_),
    .we     (ram_we),
    .waddr  (wr_ptr[PTR-1:0]),
    .wdata  ({wrlast, datain}),
    .re     (rd_ok),
    .raddr  (rd_ptr[PTR-1:0]),
    .rdata  (ram_q)
  );

  assign dataout      = ram_q[WIDTH-1:0];
  assign dataout_last = ram_q[WIDTH];
endmodule

// File: tb/tb_txdata_pkt_fifo.sv
// Directed bench for txdata_pkt_fifo; covers whichever build TXDATA_PKT_FIFO_STORE_FWD_EN selects.
module tb_txdata_pkt_fifo;
  logic        clk = 1'b0;
  logic        reset_ = 1'b0;
  logic        wren = 1'b0, wrlast = 1'b0, wrabort = 1'b0, rden = 1'b0;
  logic [63:0] datain = '0;
  logic        wrfull, wrafull, dataout_last, rdempty, ovf, udf, dbg;
  logic [8:0]  wrusedw, rdusedw, pktcnt;
  logic [63:0] dataout;
  int          total = 0;
  int          bad = 0;

  txdata_pkt_fifo dut (
    .clk(clk), .reset_(reset_), .wren(wren), .datain(datain), .wrlast(wrlast),
    .wrabort(wrabort), .wrfull(wrfull), .wrafull(wrafull), .wrusedw(wrusedw),
    .rden(rden), .dataout(dataout), .dataout_last(dataout_last), .rdempty(rdempty),
    .rdusedw(rdusedw), .pktcnt(pktcnt), .ovf(ovf), .udf(udf), .dbg(dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [63:0] d, input logic l);
    wren = 1'b1; datain = d; wrlast = l;
    tick();
    wren = 1'b0; wrlast = 1'b0;
  endtask

  task automatic rd();
    rden = 1'b1;
    tick();
    rden = 1'b0;
  endtask

  task automatic do_reset();
    reset_ = 1'b0; wren = 1'b0; rden = 1'b0; wrabort = 1'b0;
    tick(); tick();
    reset_ = 1'b1;
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_dataout"}, dataout, 64'h0);
    chk({p, "_last"},    {63'h0, dataout_last}, 64'h0);
    chk({p, "_wrfull"},  {63'h0, wrfull}, 64'h0);
    chk({p, "_wrafull"}, {63'h0, wrafull}, 64'h0);
    chk({p, "_wrusedw"}, {55'h0, wrusedw}, 64'h0);
    chk({p, "_rdempty"}, {63'h0, rdempty}, 64'h1);
    chk({p, "_rdusedw"}, {55'h0, rdusedw}, 64'h0);
    chk({p, "_pktcnt"},  {55'h0, pktcnt}, 64'h0);
    chk({p, "_ovf"},     {63'h0, ovf}, 64'h0);
    chk({p, "_udf"},     {63'h0, udf}, 64'h0);
    chk({p, "_dbg"},     {63'h0, dbg}, 64'h0);
  endtask

  initial begin
    // Reset state, then underflow at reset exit
    tick(); tick();
    chk_reset_vals("rst");
    reset_ = 1'b1; rden = 1'b1;
    tick();
    rden = 1'b0;
    chk("udf_exit", {63'h0, udf}, 64'h1);
    chk("udf_dout", dataout, 64'h0);
    chk("udf_empty", {63'h0, rdempty}, 64'h1);

    // 4-word packet A1..A4
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      wr(64'hA000_0000_0000_0000 | 64'(i), i == 4);
`ifdef TXDATA_PKT_FIFO_STORE_FWD_EN
      chk($sformatf("a_empty%0d", i), {63'h0, rdempty}, (i == 4) ? 64'h0 : 64'h1);
`else
      chk($sformatf("a_rdused%0d", i), {55'h0, rdusedw}, 64'(i));
`endif
    end
    chk("a_pkt1", {55'h0, pktcnt}, 64'h1);
    chk("a_wrused", {55'h0, wrusedw}, 64'h4);
    for (int i = 1; i <= 4; i++) begin
      rd();
      chk($sformatf("a_data%0d", i), dataout, 64'hA000_0000_0000_0000 | 64'(i));
      chk($sformatf("a_last%0d", i), {63'h0, dataout_last}, (i == 4) ? 64'h1 : 64'h0);
      chk($sformatf("a_pkt_r%0d", i), {55'h0, pktcnt}, (i == 4) ? 64'h0 : 64'h1);
    end
    chk("a_empty_end", {63'h0, rdempty}, 64'h1);

    // Abort on the 4th word of packet B, then packet C
    for (int i = 1; i <= 3; i++) wr(64'hB0 + 64'(i), 1'b0);
    wrabort = 1'b1;
    wr(64'hB4, 1'b0);
    wrabort = 1'b0;
`ifdef TXDATA_PKT_FIFO_STORE_FWD_EN
    chk("b_wrused", {55'h0, wrusedw}, 64'h0);
    chk("b_empty", {63'h0, rdempty}, 64'h1);
    chk("b_pkt", {55'h0, pktcnt}, 64'h0);
    wr(64'hC1, 1'b0);
    wr(64'hC2, 1'b1);
    rd(); chk("c_d1", dataout, 64'hC1); chk("c_l1", {63'h0, dataout_last}, 64'h0);
    rd(); chk("c_d2", dataout, 64'hC2); chk("c_l2", {63'h0, dataout_last}, 64'h1);
`else
    chk("b_wrused", {55'h0, wrusedw}, 64'h4);
    chk("b_rdused", {55'h0, rdusedw}, 64'h4);
    wr(64'hC1, 1'b0);
    wr(64'hC2, 1'b1);
    chk("c_pkt", {55'h0, pktcnt}, 64'h1);
    for (int i = 1; i <= 4; i++) begin
      rd();
      chk($sformatf("b_d%0d", i), dataout, 64'hB0 + 64'(i));
    end
    rd(); chk("c_d1", dataout, 64'hC1);
    rd(); chk("c_d2", dataout, 64'hC2); chk("c_l2", {63'h0, dataout_last}, 64'h1);
`endif
    chk("c_pkt0", {55'h0, pktcnt}, 64'h0);
    chk("c_empty", {63'h0, rdempty}, 64'h1);

    // 300-word packet into a 256-word FIFO
    do_reset();
    for (int i = 1; i <= 300; i++) begin
      wren = 1'b1; datain = 64'(i); wrlast = (i == 300);
      tick();
      if (i == 239) chk("big_afull239", {63'h0, wrafull}, 64'h0);
      if (i == 240) chk("big_afull240", {63'h0, wrafull}, 64'h1);
      if (i == 256) begin
        chk("big_full256", {63'h0, wrfull}, 64'h1);
        chk("big_ovf256", {63'h0, ovf}, 64'h0);
      end
      if (i == 257) begin
        chk("big_ovf257", {63'h0, ovf}, 64'h1);
`ifdef TXDATA_PKT_FIFO_STORE_FWD_EN
        chk("big_dbg257", {63'h0, dbg}, 64'h1);
        chk("big_wrused257", {55'h0, wrusedw}, 64'h0);
`else
        chk("big_dbg257", {63'h0, dbg}, 64'h0);
        chk("big_wrused257", {55'h0, wrusedw}, 64'd256);
`endif
      end
`ifdef TXDATA_PKT_FIFO_STORE_FWD_EN
      if (i == 299) chk("big_dbg299", {63'h0, dbg}, 64'h1);
`endif
    end
    wren = 1'b0; wrlast = 1'b0;
    chk("big_dbg_end", {63'h0, dbg}, 64'h0);
`ifdef TXDATA_PKT_FIFO_STORE_FWD_EN
    chk("big_wrused_end", {55'h0, wrusedw}, 64'h0);
    chk("big_empty_end", {63'h0, rdempty}, 64'h1);
    wr(64'hD1, 1'b1);
    rd();
    chk("d_data", dataout, 64'hD1);
    chk("d_last", {63'h0, dataout_last}, 64'h1);
`else
    chk("big_rdused_end", {55'h0, rdusedw}, 64'd256);
    chk("big_pkt_end", {55'h0, pktcnt}, 64'h0);
    rd();
    chk("big_first", dataout, 64'h1);
`endif

    // Full FIFO with simultaneous rejected write and read
    do_reset();
    for (int i = 0; i < 256; i++) wr(64'h100 + 64'(i), i == 255);
    chk("full_wrfull", {63'h0, wrfull}, 64'h1);
    chk("full_rdused", {55'h0, rdusedw}, 64'd256);
    chk("full_pkt", {55'h0, pktcnt}, 64'h1);
    wren = 1'b1; datain = 64'hDEAD; wrlast = 1'b0; rden = 1'b1;
    tick();
    wren = 1'b0; rden = 1'b0;
    chk("full_ovf", {63'h0, ovf}, 64'h1);
    chk("full_wrused", {55'h0, wrusedw}, 64'd255);
    chk("full_rdused2", {55'h0, rdusedw}, 64'd255);
    chk("full_dout", dataout, 64'h100);
    chk("full_pkt2", {55'h0, pktcnt}, 64'h1);
`ifdef TXDATA_PKT_FIFO_STORE_FWD_EN
    chk("full_dbg", {63'h0, dbg}, 64'h1);
`else
    chk("full_dbg", {63'h0, dbg}, 64'h0);
`endif

    // Reset mid-packet
    do_reset();
    wr(64'hE1, 1'b1);
    rd();
    chk("e_data", dataout, 64'hE1);
    wr(64'hF1, 1'b0);
    wr(64'hF2, 1'b0);
    chk("f_wrused", {55'h0, wrusedw}, 64'h2);
    reset_ = 1'b0;
    tick();
    reset_ = 1'b1;
    chk_reset_vals("midrst");

    // Single word without last: visibility 2 cycles after the write
    wr(64'h61, 1'b0);
`ifdef TXDATA_PKT_FIFO_STORE_FWD_EN
    chk("g_empty", {63'h0, rdempty}, 64'h1);
`else
    chk("g_empty", {63'h0, rdempty}, 64'h0);
    rd();
    chk("g_data", dataout, 64'h61);
    chk("g_last", {63'h0, dataout_last}, 64'h0);
    chk("g_udf", {63'h0, udf}, 64'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
